// File: rtl/sobel_window_ctrl.sv
// Streaming 5x5 window sequencer for an external combinational Sobel-Y kernel.
// Optional macro SOBEL_THRESH_EN adds a thresh port and binarises the output.
module sobel_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef SOBEL_THRESH_EN
  input  logic [7:0]   thresh,
`endif
  input  logic         start,
  input  logic [7:0]   in_pixel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [199:0] win_out,
  input  logic [7:0]   kern_pixel,
  output logic [7:0]   out_pixel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         frame_done
);

  // state | meaning
  // IDLE  | waiting for start, no input accepted
  // FILL  | rows 0..3 priming line buffers, no output
  // RUN   | rows 4..IMG_H-1, output for cols >= 4
  // DRAIN | input closed, flushing the last pending/held output
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] ROW_FILL  = CNT_W'(3);
  localparam logic [CNT_W-1:0] EDGE_POS  = CNT_W'(4);

  state_t state, state_nxt;

  logic [CNT_W-1:0] row, col;
  logic [7:0]       win [5][5];
  logic [7:0]       lb0 [IMG_W];
  logic [7:0]       lb1 [IMG_W];
  logic [7:0]       lb2 [IMG_W];
  logic [7:0]       lb3 [IMG_W];
  logic [AW-1:0]    lb_addr;
  logic             pending;
  logic             out_free, accept, load, col_last, row_last, out_pos;
  logic             start_frame, finish;
  logic [7:0]       result;

  assign lb_addr  = col[AW-1:0];
  assign out_free = !out_valid || out_ready;
  assign in_ready = ((state == S_FILL) || (state == S_RUN)) && out_free;
  assign accept   = in_valid && in_ready;
  assign load     = pending && out_free;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign out_pos  = (row >= EDGE_POS) && (col >= EDGE_POS);

`ifdef SOBEL_THRESH_EN
  assign result = (kern_pixel >= thresh) ? 8'hFF : 8'h00;
`else
  assign result = kern_pixel;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    finish      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_FILL;
          start_frame = 1'b1;
        end
      end
      S_FILL: begin
        if (accept && col_last && (row == ROW_FILL)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (accept && col_last && row_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Done once nothing awaits loading and the held output leaves now.
        if (!pending && out_free) begin
          state_nxt = S_IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      pending    <= 1'b0;
      out_pixel  <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          win[r][c] <= '0;
    end else begin
      frame_done <= finish;
      if (start_frame) begin
        row  <= '0;
        col  <= '0;
        busy <= 1'b1;
      end
      if (finish) busy <= 1'b0;

      if (accept) begin
        if (col_last) begin
          col <= '0;
          if (!row_last) row <= row + CNT_W'(1);
        end else begin
          col <= col + CNT_W'(1);
        end
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 4; c++)
            win[r][c] <= win[r][c+1];
        win[0][4] <= lb3[lb_addr];
        win[1][4] <= lb2[lb_addr];
        win[2][4] <= lb1[lb_addr];
        win[3][4] <= lb0[lb_addr];
        win[4][4] <= in_pixel;
        // accept implies out_free, so any older pending result loads this edge
        pending <= out_pos;
      end else if (load) begin
        pending <= 1'b0;
      end

      if (load) begin
        out_pixel <= result;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Line buffers carry no reset; contents are rewritten before use each frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb3[lb_addr] <= lb2[lb_addr];
      lb2[lb_addr] <= lb1[lb_addr];
      lb1[lb_addr] <= lb0[lb_addr];
      lb0[lb_addr] <= in_pixel;
    end
  end

  always_comb begin
    win_out = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        win_out[(r*5+c)*8 +: 8] = win[r][c];
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl: an 8x8 and a 16x12 instance share stimulus,
// selected by sel; the bench supplies the Sobel-Y kernel and a frame-level golden model.
module tb_sobel_window_ctrl;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, in_valid, out_ready, sel;
  logic [7:0]   in_pixel;
`ifdef SOBEL_THRESH_EN
  logic [7:0]   thresh;
`endif

  logic         rdy_a, ov_a, busy_a, fd_a, rdy_b, ov_b, busy_b, fd_b;
  logic [199:0] win_a, win_b;
  logic [7:0]   kern_a, kern_b, opix_a, opix_b;
  logic         start_a, start_b;

  logic         in_ready, out_valid, busy, frame_done;
  logic [7:0]   out_pixel;
  logic [199:0] win_out;

  function automatic logic [7:0] sobel_y(input logic [199:0] w);
    int dv[5] = '{-1, -2, 0, 2, 1};
    int sm[5] = '{1, 4, 6, 4, 1};
    int acc = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        acc += dv[r] * sm[c] * int'(w[(r*5+c)*8 +: 8]);
    if (acc < 0) acc = -acc;
    acc = acc / 16;
    if (acc > 255) acc = 255;
    return 8'(acc);
  endfunction

  assign kern_a  = sobel_y(win_a);
  assign kern_b  = sobel_y(win_b);
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign in_ready   = sel ? rdy_b  : rdy_a;
  assign out_valid  = sel ? ov_b   : ov_a;
  assign busy       = sel ? busy_b : busy_a;
  assign frame_done = sel ? fd_b   : fd_a;
  assign out_pixel  = sel ? opix_b : opix_a;
  assign win_out    = sel ? win_b  : win_a;

  sobel_window_ctrl #(.IMG_W(8), .IMG_H(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef SOBEL_THRESH_EN
    .thresh(thresh),
`endif
    .start(start_a), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(rdy_a),
    .win_out(win_a), .kern_pixel(kern_a), .out_pixel(opix_a), .out_valid(ov_a),
    .out_ready(out_ready), .busy(busy_a), .frame_done(fd_a)
  );

  sobel_window_ctrl #(.IMG_W(16), .IMG_H(12)) dut_b (
    .clk(clk), .rst_n(rst_n),
`ifdef SOBEL_THRESH_EN
    .thresh(thresh),
`endif
    .start(start_b), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(rdy_b),
    .win_out(win_b), .kern_pixel(kern_b), .out_pixel(opix_b), .out_valid(ov_b),
    .out_ready(out_ready), .busy(busy_b), .frame_done(fd_b)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_out, hs_cyc;
  logic [7:0] exp_q[$];
  logic [7:0] img [12][16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_at(input int r, input int c);
    logic [199:0] w;
    logic [7:0]   e;
    w = '0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 5; j++)
        w[(k*5+j)*8 +: 8] = img[r-4+k][c-4+j];
    e = sobel_y(w);
`ifdef SOBEL_THRESH_EN
    e = (e >= thresh) ? 8'hFF : 8'h00;
`endif
    return e;
  endfunction

  // Output side: pop the scoreboard on every handshake, watch back-pressure.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        hs_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else                   chk("out_pixel", out_pixel, exp_q.pop_front());
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
    end
  end

  task automatic run_frame(input int mode, input bit rnd, input int mid_start, input int abort_at);
    int  w, h, idx, guard, r, c, fd_cyc, fd_cnt;
    bit  win_chk, got_fd;
    w = sel ? 16 : 8;
    h = sel ? 12 : 8;
    for (int i = 0; i < h; i++)
      for (int j = 0; j < w; j++)
        case (mode)
          0: img[i][j] = 8'd100;
          1: img[i][j] = 8'(i * 10);
          2: img[i][j] = 8'(j * 10);
          3: img[i][j] = (i == 4 && j == 4) ? 8'd255 : 8'd0;
          default: img[i][j] = 8'($urandom_range(0, 255));
        endcase
    n_out = 0;
    exp_q.delete();
    win_chk = 1'b0;

    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);

    idx = 0;
    guard = 0;
    while (idx < w * h && guard < 20000) begin
      if (win_chk) begin
        chk("win_r4c4", win_out[199:192], 8'd255);
        win_chk = 1'b0;
      end
      if (idx == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_pixel", out_pixel, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fd_cnt = 0;
        repeat (20) begin
          @(negedge clk);
          if (frame_done) fd_cnt++;
        end
        chk("abort_no_frame_done", fd_cnt, 0);
        exp_q.delete();
        return;
      end
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pixel  = img[idx / w][idx % w];
      start     = (idx == mid_start);
      @(negedge clk);
      if (in_valid && in_ready) begin
        r = idx / w;
        c = idx % w;
        if (r >= 4 && c >= 4) exp_q.push_back(exp_at(r, c));
        if (mode == 3 && r == 4 && c == 4) win_chk = 1'b1;
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (guard >= 20000) chk("input_timeout", idx, w * h);

    got_fd = 1'b0;
    fd_cyc = 0;
    guard = 0;
    while (!got_fd && guard < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (frame_done) begin
        got_fd = 1'b1;
        fd_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
      guard++;
    end
    chk("frame_done_seen", got_fd, 1);
    chk("out_count", n_out, (w - 4) * (h - 4));
    chk("fd_latency", fd_cyc - hs_cyc, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("frame_done_pulse", frame_done, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = 8'd0;
    out_ready = 1'b1; sel = 1'b0;
    n_out = 0; hs_cyc = 0;
`ifdef SOBEL_THRESH_EN
    thresh = 8'd1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_pixel", out_pixel, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_win_zero", (win_out == '0), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_frame(0, 1'b0, -1, -1);
`ifdef SOBEL_THRESH_EN
    thresh = 8'd50;
    run_frame(1, 1'b0, -1, -1);
    thresh = 8'd81;
    run_frame(1, 1'b0, -1, -1);
    thresh = 8'd1;
`else
    run_frame(1, 1'b0, -1, -1);
`endif
    run_frame(2, 1'b0, -1, -1);
    run_frame(3, 1'b0, -1, -1);
    run_frame(1, 1'b0, 40, -1);
    run_frame(4, 1'b0, -1, 45);
    run_frame(4, 1'b0, -1, -1);

    sel = 1'b1;
`ifdef SOBEL_THRESH_EN
    thresh = 8'd40;
`endif
    run_frame(4, 1'b1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Streaming controller that sequences the combinational 5x5 Sobel-Y kernel (Edge_Y) over a raster-order 8-bit greyscale frame.
- Accepts one pixel per handshake and keeps 4 line buffers plus a 5x5 window register.
- Presents the packed 200-bit window to the kernel and registers the kernel result onto a valid/ready output stream.
- Sits between the decoder's colour-converted Y output and the filter output FIFO.

Parameters:
- IMG_W, 640, frame width in pixels (>= 5)
- IMG_H, 480, frame height in pixels (>= 5)
- CNT_W, 10, width of row/column counters (must hold max(IMG_W, IMG_H))

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE
- in_pixel  in  8  input pixel, raster order
- in_valid  in  1  input pixel valid
- in_ready  out  1  controller accepts in_pixel this cycle
- win_out  out  200  window to kernel; row r (0 = oldest/top), col c (0 = leftmost) at bits [(r*5+c)*8 +: 8]
- kern_pixel  in  8  kernel result for win_out (combinational return)
- out_pixel  out  8  filtered pixel
- out_valid  out  1  out_pixel valid
- out_ready  in  1  downstream accepts out_pixel
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset: state=IDLE; counters, window, out_pixel=0; out_valid=0, busy=0, frame_done=0, in_ready=0. Line buffer contents are don't-care.
- Reset may assert at any time. The frame is abandoned with no frame_done, and the next frame needs a new start.
- States and transitions:
  - IDLE: in_ready=0. On start, reset row=col=0, set busy=1 and go to FILL.
  - FILL: rows 0..3 are accepted with no output. Go to RUN when row 3, col IMG_W-1 is accepted.
  - RUN: rows 4..IMG_H-1. Go to DRAIN when the last pixel is accepted.
  - DRAIN: in_ready=0. Wait until out_valid=0 or the pending output handshakes, then pulse frame_done, clear busy and go to IDLE.
- start outside IDLE is ignored.
- Handshake: in_ready = (state is FILL or RUN) and (!out_valid or out_ready). A pixel is accepted when in_valid and in_ready.
- Output register: out_valid clears on out_valid and out_ready with no new load. A simultaneous load and drain keeps out_valid=1 with the new data.
- On each accepted pixel at (row, col):
  - Line buffers, per column address col: lb3<=lb2[col], lb2<=lb1[col], lb1<=lb0[col], lb0<=in_pixel.
  - Window: all rows shift left one column. The new column 4 is {lb3[col], lb2[col], lb1[col], lb0[col], in_pixel} for rows 0..4.
  - col increments and wraps to 0 at IMG_W-1, which increments row. row stops counting after IMG_H-1.
  - A pixel with row>=4 and col>=4 is an output position. On the next cycle win_out holds its window, and kern_pixel is loaded into out_pixel with out_valid set, one cycle after acceptance. Load is enabled by an internal pending flag.
- Window contents across row wrap are stale for cols 0..3. These positions never produce output, so this is allowed.
- Outputs per frame: exactly (IMG_W-4)*(IMG_H-4), in raster order. There is no border padding.
- Back-pressure: while out_valid=1 and out_ready=0, in_ready=0 and all state, window and counters hold.

Optional Feature:
- Macro: SOBEL_THRESH_EN.
- Defined:
  - Adds an input port thresh (8 bits).
  - out_pixel = (kern_pixel >= thresh) ? 8'hFF : 8'h00.
  - thresh is sampled at the same edge as the output load.
- Undefined: no thresh port; out_pixel = kern_pixel unchanged.

Test Plan:
- IMG_W=8, IMG_H=8, constant pixel 100, out_ready=1 -> exactly 16 outputs, all 0; frame_done one cycle after 16th handshake; busy low afterward.
- Vertical ramp pixel=row*10, same size -> 16 outputs, all 80. Horizontal ramp pixel=col*10 -> all 0.
- Single impulse 255 at (4,4), rest 0 -> first output (window centre (2,2)) equals kern_pixel for the impulse in row4/col4 slot; check win_out bit [199:192]=255 on that cycle.
- Random out_ready (50%) and in_valid (50%) over a 16x12 frame -> 96 outputs matching the golden model in order; no in_pixel is accepted while out_valid && !out_ready.
- start pulse during RUN -> ignored, frame completes normally. rst_n low mid-RUN -> all outputs 0 immediately, no frame_done. A new start then yields a correct full frame.
- With SOBEL_THRESH_EN and thresh=50 on the vertical ramp -> all outputs 8'hFF. With thresh=81 -> all 8'h00.
